// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing used by both the pixel generator
// and the decoder, count widths, and the decoder lock-state encoding.
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int H_W = 11;
    localparam int V_W = 10;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_COUNT    = 2'd1,
        LK_LOCKED   = 2'd2
    } lock_state_t;
endpackage

// File: rtl/vga_edge_det.sv
// Single-signal edge detector; the history register only updates when en is
// high, so edges are judged between consecutive qualified samples.
module vga_edge_det #(
    parameter bit FALLING = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic hit
);
    logic q;

    // History resets high so a signal already low out of reset reads as a fall.
    always_ff @(posedge clk) begin
        if (rst)     q <= 1'b1;
        else if (en) q <= d;
    end

    assign hit = FALLING ? (en & q & ~d) : (en & ~q & d);
endmodule

// File: rtl/vga_sync_decoder.sv
// Receive side of the VGA pixel interface: recovers pixel strobe, X/Y and RGB,
// measures line/frame totals and tracks timing lock.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           CLOCK_50,
    input  logic           RESET,
    input  logic           VGA_CLK,
    input  logic           VGA_HS,
    input  logic           VGA_VS,
    input  logic           VGA_BLANK_N,
    input  logic [7:0]     VGA_R,
    input  logic [7:0]     VGA_G,
    input  logic [7:0]     VGA_B,
    output logic           pix_valid,
    output logic [H_W-1:0] pix_x,
    output logic [V_W-1:0] pix_y,
    output logic [23:0]    pix_rgb,
    output logic           line_start,
    output logic           frame_start,
    output logic [H_W-1:0] h_total_meas,
    output logic [V_W-1:0] v_total_meas,
    output logic           locked,
    output logic           timing_err
);
    logic           pstb, hs_fall, vs_fall;
    logic [H_W-1:0] h_cnt, x, x_cur;
    logic [V_W-1:0] y, v_cnt, y_line, y_cur, v_line;
    logic           y_seen, h_err, v_err, bad;
    logic [3:0]     good_cnt;
    logic           frame_bad;
    lock_state_t    state;

    vga_edge_det #(.FALLING(1'b0)) u_clk_det (
        .clk(CLOCK_50), .rst(RESET), .en(1'b1), .d(VGA_CLK), .hit(pstb));
    vga_edge_det #(.FALLING(1'b1)) u_hs_det (
        .clk(CLOCK_50), .rst(RESET), .en(pstb), .d(VGA_HS), .hit(hs_fall));
    vga_edge_det #(.FALLING(1'b1)) u_vs_det (
        .clk(CLOCK_50), .rst(RESET), .en(pstb), .d(VGA_VS), .hit(vs_fall));

    // Line actions feed frame actions so a coincident HS/VS fall is judged
    // with the closing line already counted.
    always_comb begin
        y_line = y;
        v_line = v_cnt;
        if (hs_fall) begin
            if (y_seen && (y != '1)) y_line = y + 1'b1;
            if (v_cnt != '1)         v_line = v_cnt + 1'b1;
        end
        x_cur = hs_fall ? '0 : x;
        y_cur = vs_fall ? '0 : y_line;
        h_err = (h_cnt == '1) || ((h_cnt + 1'b1) != H_W'(H_TOTAL)) ||
                (y_seen && (x != H_W'(H_ACTIVE)));
        v_err = (v_line == '1) || (v_line != V_W'(V_TOTAL)) ||
                (y_line == '1) || (y_line != V_W'(V_ACTIVE));
        bad   = (hs_fall && h_err) || (vs_fall && v_err);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            h_cnt <= '0; x <= '0; y <= '0; v_cnt <= '0; y_seen <= 1'b0;
            pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0; pix_rgb <= '0;
            line_start <= 1'b0; frame_start <= 1'b0;
            h_total_meas <= '0; v_total_meas <= '0;
        end else begin
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pstb) begin
                line_start  <= hs_fall;
                frame_start <= vs_fall;
                y           <= y_cur;
                v_cnt       <= vs_fall ? '0 : v_line;
                if (hs_fall) begin
                    h_cnt        <= '0;
                    h_total_meas <= (h_cnt == '1) ? '1 : h_cnt + 1'b1;
                end else if (h_cnt != '1) begin
                    h_cnt <= h_cnt + 1'b1;
                end
                if (vs_fall) v_total_meas <= v_line;
                if (VGA_BLANK_N) begin
                    pix_valid <= 1'b1;
                    pix_x     <= x_cur;
                    pix_y     <= y_cur;
                    pix_rgb   <= {VGA_R, VGA_G, VGA_B};
                    x         <= (x_cur == '1) ? x_cur : x_cur + 1'b1;
                    y_seen    <= 1'b1;
                end else begin
                    x <= x_cur;
                    if (hs_fall) y_seen <= 1'b0;
                end
            end
        end
    end

    // A frame only counts as good if nothing failed anywhere inside it.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= LK_UNLOCKED; good_cnt <= '0; frame_bad <= 1'b0;
            locked <= 1'b0; timing_err <= 1'b0;
        end else if (pstb) begin
            case (state)
                LK_UNLOCKED: begin
                    if (vs_fall) begin
                        state     <= LK_COUNT;
                        good_cnt  <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                default: begin
                    if (bad) begin
                        state      <= LK_COUNT;
                        good_cnt   <= '0;
                        locked     <= 1'b0;
                        timing_err <= 1'b1;
                        frame_bad  <= ~vs_fall;
                    end else if (vs_fall) begin
                        frame_bad <= 1'b0;
                        if (state == LK_COUNT && !frame_bad) begin
                            good_cnt <= good_cnt + 4'd1;
                            if ((good_cnt + 4'd1) == 4'(LOCK_FRAMES)) begin
                                state  <= LK_LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: scaled-down raster generator, pixel scoreboard
// and directed checks for lock, stretch, stall, reset and coincident syncs.
module tb_vga_sync_decoder;
    import vga_pkg::*;

    localparam int HA = 16, HT = 24, HS_BEG = 18, HS_END = 22;
    localparam int VA = 6, VT = 11;
    localparam int VS_BEG = 7 * HT + HS_BEG, VS_END = 9 * HT + HS_BEG;

    logic CLOCK_50 = 1'b0, RESET = 1'b1, VGA_CLK = 1'b0;
    logic VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLANK_N = 1'b0;
    logic [7:0] VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic pix_valid, line_start, frame_start, locked, timing_err;
    logic [H_W-1:0] pix_x, h_total_meas;
    logic [V_W-1:0] pix_y, v_total_meas;
    logic [23:0] pix_rgb;

    vga_sync_decoder #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
                       .LOCK_FRAMES(2)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .line_start(line_start), .frame_start(frame_start),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
        .locked(locked), .timing_err(timing_err));

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_chk = 0, n_fail = 0;
    int gv = 0, gh = 0, n_strobe = 0;
    int m_x = 0, m_y = 0;
    logic m_seen = 1'b0, m_hs = 1'b1, m_vs = 1'b1;
    logic [44:0] sb_q[$];
    logic [44:0] sb_e;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk_eq({tag, "_pix_valid"}, pix_valid, 0);
        chk_eq({tag, "_pix_x"}, pix_x, 0);
        chk_eq({tag, "_pix_y"}, pix_y, 0);
        chk_eq({tag, "_pix_rgb"}, pix_rgb, 0);
        chk_eq({tag, "_line_start"}, line_start, 0);
        chk_eq({tag, "_frame_start"}, frame_start, 0);
        chk_eq({tag, "_h_meas"}, h_total_meas, 0);
        chk_eq({tag, "_v_meas"}, v_total_meas, 0);
        chk_eq({tag, "_locked"}, locked, 0);
        chk_eq({tag, "_timing_err"}, timing_err, 0);
    endtask

    // One pixel strobe (VGA_CLK high one cycle, low one cycle) plus the
    // expected-pixel model; returns when the strobe's outputs are visible.
    task automatic drive(input int v, input int h);
        int p = v * HT + h;
        logic hs, vs, bl;
        logic [23:0] rgb;
        hs  = !(h >= HS_BEG && h < HS_END);
        vs  = !(p >= VS_BEG && p < VS_END);
        bl  = (h < HA) && (v < VA);
        rgb = (h == 0 && v == 0) ? 24'h3DD198 : {8'(h * 7), 8'(v * 13), 8'(n_strobe)};
        n_strobe++;
        @(negedge CLOCK_50);
        VGA_CLK = 1'b1; VGA_HS = hs; VGA_VS = vs; VGA_BLANK_N = bl;
        {VGA_R, VGA_G, VGA_B} = rgb;
        if (m_hs && !hs) begin
            m_x = 0;
            if (m_seen && m_y < 1023) m_y++;
            m_seen = 1'b0;
        end
        if (m_vs && !vs) m_y = 0;
        if (bl) begin
            sb_q.push_back({11'(m_x), 10'(m_y), rgb});
            if (m_x < 2047) m_x++;
            m_seen = 1'b1;
        end
        m_hs = hs; m_vs = vs;
        @(negedge CLOCK_50);
        VGA_CLK = 1'b0;
    endtask

    task automatic step();
        drive(gv, gh);
        if (gh == HT - 1) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh++;
        end
    endtask

    task automatic run_to(input int v, input int h);
        for (int i = 0; i < VT * HT && !(gv == v && gh == h); i++) step();
    endtask

    task automatic next_frame(input string tag, input logic exp_lock);
        run_to(7, HS_BEG);
        step();
        chk_eq({tag, "_frame_start"}, frame_start, 1);
        chk_eq({tag, "_line_start"}, line_start, 1);
        chk_eq({tag, "_locked"}, locked, exp_lock);
    endtask

    always @(posedge CLOCK_50) begin
        #1;
        if (sb_q.size() != 0) begin
            sb_e = sb_q.pop_front();
            chk_eq("pix_valid", pix_valid, 1);
            if (pix_valid) begin
                chk_eq("pix_x", pix_x, sb_e[44:34]);
                chk_eq("pix_y", pix_y, sb_e[33:24]);
                chk_eq("pix_rgb", pix_rgb, sb_e[23:0]);
            end
        end else if (pix_valid) begin
            chk_eq("pix_valid_spurious", pix_valid, 0);
        end
    end

    initial begin
        int pulses;
        repeat (3) @(negedge CLOCK_50);
        chk_zero("reset");
        RESET = 1'b0;
        gv = 7; gh = HS_BEG;

        // First strobe has HS and VS already low: both falls, lock counting starts.
        step();
        chk_eq("f1_frame_start", frame_start, 1);
        chk_eq("f1_line_start", line_start, 1);
        chk_eq("f1_locked", locked, 0);
        next_frame("f2", 1'b0);
        next_frame("f3", 1'b1);
        chk_eq("f3_h_meas", h_total_meas, HT);
        chk_eq("f3_v_meas", v_total_meas, VT);
        chk_eq("f3_timing_err", timing_err, 0);

        // VGA_CLK stalled mid-line.
        run_to(3, 5);
        pulses = 0;
        repeat (1000) begin
            @(negedge CLOCK_50);
            pulses += int'(pix_valid) + int'(line_start) + int'(frame_start);
        end
        chk_eq("stall_pulses", pulses, 0);
        chk_eq("stall_pix_x", pix_x, 4);
        chk_eq("stall_pix_y", pix_y, 3);
        run_to(3, HS_BEG);
        step();
        chk_eq("stall_line_start", line_start, 1);
        chk_eq("stall_h_meas", h_total_meas, HT);
        chk_eq("stall_locked", locked, 1);
        chk_eq("stall_timing_err", timing_err, 0);

        // One line stretched by a single blank strobe.
        next_frame("pre_stretch", 1'b1);
        run_to(2, HS_BEG);
        drive(2, HS_BEG - 1);
        step();
        chk_eq("stretch_line_start", line_start, 1);
        chk_eq("stretch_h_meas", h_total_meas, HT + 1);
        chk_eq("stretch_timing_err", timing_err, 1);
        chk_eq("stretch_locked", locked, 0);
        next_frame("stretch_end", 1'b0);
        next_frame("clean1", 1'b0);
        next_frame("clean2", 1'b1);
        chk_eq("clean2_timing_err", timing_err, 1);

        // Reset in the middle of an active line.
        run_to(3, 10);
        RESET = 1'b1;
        @(negedge CLOCK_50);
        chk_zero("midreset");
        RESET = 1'b0;
        m_x = 0; m_y = 0; m_seen = 1'b0; m_hs = 1'b1; m_vs = 1'b1;
        next_frame("rst_vs1", 1'b0);
        chk_eq("rst_vs1_timing_err", timing_err, 0);
        next_frame("rst_vs2", 1'b0);
        next_frame("rst_vs3", 1'b1);
        chk_eq("rst_h_meas", h_total_meas, HT);
        chk_eq("rst_v_meas", v_total_meas, VT);
        chk_eq("rst_timing_err", timing_err, 0);

        run_to(1, 0);
        repeat (2) @(negedge CLOCK_50);
        chk_eq("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
